mef1_responder: RTL and testbench
=================================

# mef1_responder

Station-side responder for the `mef1` motor controller. It drives the controller's sensor and command inputs (`g`, `s`, `ev`, `rd`, `back`) and reacts to the controller's outputs (`M`, `D`, `LEV`, `Lerro`), so it stands in for the physical station. It sequences one start, then repeating travel/block/dwell/return trips. It also flags any controller output that breaks the protocol. The block is used both as the on-chip station model and as the bring-up stimulus source.

## Interface
Parameters:
- `TRAVEL_CYCLES`, default 4: number of `M`-high cycles before the end-of-travel event; must be ≥1.
- `CLEAR_CYCLES`, default 3: number of cycles `rd` is held high (blocked); must be ≥1.
- `DWELL_CYCLES`, default 2: number of `D`-high cycles before `back` is pulsed; must be ≥1.

Ports:
- `clk`, input, 1: single clock; everything is rising-edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: operator request; sampled only in IDLE.
- `M`, `D`, `LEV`, `Lerro`, input, 1 each: controller outputs.
- `g`, `s`, output, 1 each: guard/start lines; low on both means "go".
- `ev`, output, 1: end-of-travel sensor pulse.
- `rd`, output, 1: station blocked; high means not ready.
- `back`, output, 1: return acknowledge pulse.
- `trips`, output, 8: count of completed trips; wraps from 255 to 0.
- `fault`, output, 1: sticky protocol violation flag.
- `phase`, output, 3: current state encoding, for debug.

## Operation
- All outputs are registered.
- Reset values: `g`=1, `s`=1, `ev`=0, `rd`=0, `back`=0, `trips`=0, `fault`=0, state IDLE.
- States and transitions:
  - IDLE: waits for `start`=1, then goes to ARM.
  - ARM: holds `g`=`s`=0 for exactly 1 cycle, then goes to TRAVEL. `g` and `s` are 1 in every other state.
  - TRAVEL: counts cycles with `M`=1. When the count reaches `TRAVEL_CYCLES`, goes to EVENT. Cycles with `M`=0 do not count.
  - EVENT: holds `ev`=1 for 1 cycle, then goes to BLOCKED.
  - BLOCKED: holds `rd`=1 for `CLEAR_CYCLES` cycles, then goes to DWELL.
  - DWELL: holds `rd`=0 and counts cycles with `D`=1. When the count reaches `DWELL_CYCLES`, goes to RETURN.
  - RETURN: holds `back`=1 for 1 cycle and increments `trips`, then goes to TRAVEL.
- The cycle counter clears on every state entry.
- `start` is ignored outside IDLE. The block never returns to IDLE except through reset.
- Protocol checks are suppressed in the first cycle of each state (grace cycle). From the second cycle onward:
  - TRAVEL: requires `LEV`=1.
  - BLOCKED: requires `Lerro`=1.
  - DWELL: requires `D`=1.
  - Any state other than DWELL or RETURN: requires `D`=0.
- Any violation sets `fault` on the next edge. `fault` stays set until reset.
- Reset asserted mid-trip: all outputs return to their reset values immediately (asynchronously); the next trip starts only after a new `start`.

## Timing
- Latency from `start` sampled in IDLE to `g`/`s` low: 1 cycle.
- ARM to TRAVEL: 1 cycle. The controller enters its travel state on the same edge.
- `ev` is high for exactly 1 cycle. The controller reaches its blocked state on the same edge that `rd` rises.
- After `rd` falls, the controller raises `D` 1 cycle later; the DWELL grace cycle absorbs this lag.
- `back` is high for exactly 1 cycle. `trips` updates on the edge that ends RETURN.
- Minimum trip length, assuming an ideal controller: TRAVEL_CYCLES + 1 + CLEAR_CYCLES + (DWELL_CYCLES+1) + 1 cycles.
- Counter width is `$clog2(max(TRAVEL_CYCLES, CLEAR_CYCLES, DWELL_CYCLES)+1)`.

## Structure
- Shared package `mef1_pkg` contains:
  - the 3-bit state encoding localparams (IDLE=0, ARM=1, TRAVEL=2, EVENT=3, BLOCKED=4, DWELL=5, RETURN=6);
  - the controller state codes S0..S3 (reused by the bench monitor).
- One sub-module, `phase_counter`: a parameterised up-counter with synchronous clear, count enable and a terminal-count output. It is instantiated once and shared by TRAVEL, BLOCKED and DWELL.

## Test plan
- Paired with `mef1`, defaults, `start` pulsed at cycle 0:
  - `g`=`s`=0 in cycle 1;
  - `ev` high in cycle 6;
  - `rd` high in cycles 7–9;
  - `back` high in cycle 13;
  - `trips`=1 from cycle 14;
  - `fault`=0 throughout.
- Paired run for 300 trips: `trips` wraps from 255 to 0 at trip 256, then reads 44 after 300 trips; `fault` stays 0.
- Standalone, `M` held at 0 in TRAVEL: `ev` never asserts; `fault`=1 from the third TRAVEL cycle, because `LEV` is 0.
- Standalone, `D` forced to 1 during BLOCKED: `fault` rises 1 cycle after the first non-grace violation and stays 1 after `D` is released.
- `reset` asserted during BLOCKED: `rd` drops at once, with no clock edge needed; all outputs show reset values; `start` re-runs the sequence from ARM with `trips`=0.
- `start` pulsed during TRAVEL: no effect on state, `g`, or `s`.

Source files
------------

// File: rtl/mef1_pkg.sv
// mef1_pkg
// Definitions shared by the mef1 station responder and its bench:
//   - 3-bit responder phase codes, which are also visible on the `phase` debug port
//   - the state enum built from those codes
//   - the mef1 controller state codes S0..S3, used by station-side monitors
//   - max3(), which sizes the shared cycle counter
package mef1_pkg;

  // Responder phase codes. The values are fixed because they appear on `phase`.
  localparam logic [2:0] PH_IDLE    = 3'd0;
  localparam logic [2:0] PH_ARM     = 3'd1;
  localparam logic [2:0] PH_TRAVEL  = 3'd2;
  localparam logic [2:0] PH_EVENT   = 3'd3;
  localparam logic [2:0] PH_BLOCKED = 3'd4;
  localparam logic [2:0] PH_DWELL   = 3'd5;
  localparam logic [2:0] PH_RETURN  = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE    = PH_IDLE,
    ST_ARM     = PH_ARM,
    ST_TRAVEL  = PH_TRAVEL,
    ST_EVENT   = PH_EVENT,
    ST_BLOCKED = PH_BLOCKED,
    ST_DWELL   = PH_DWELL,
    ST_RETURN  = PH_RETURN
  } state_t;

  // mef1 controller state codes: idle, travelling, blocked, dwelling.
  localparam logic [1:0] S0 = 2'd0;
  localparam logic [1:0] S1 = 2'd1;
  localparam logic [1:0] S2 = 2'd2;
  localparam logic [1:0] S3 = 2'd3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/mef1_responder_phase_counter.sv
// phase_counter
// Up-counter shared by the timed phases of the responder.
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   clr        : synchronous clear; it takes priority over en
//   en         : count enable for this cycle
//   limit      : number of enabled cycles that completes the phase (>= 1)
//   tc         : high in the cycle whose enabled count reaches limit
module phase_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] limit,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (en)
      count <= count + WIDTH'(1);
  end

  // Terminal count looks ahead one step. The owning FSM therefore leaves on the
  // same edge that the limit-th enabled cycle ends.
  assign tc = en && ((count + WIDTH'(1)) == limit);

endmodule

// File: rtl/mef1_responder.sv
// mef1_responder
// Station-side model for the mef1 motor controller. It sequences one start,
// then endless travel/block/dwell/return trips. It also flags controller
// outputs that break the station protocol.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   start                 : operator request; honoured only in IDLE
//   M, D, LEV, Lerro      : controller outputs (motor, dwell, travel lamp, blocked lamp)
//   g, s                  : guard/start lines; both low means "go"
//   ev                    : one-cycle end-of-travel pulse
//   rd                    : station blocked (not ready)
//   back                  : one-cycle return acknowledge
//   trips                 : completed trip count; wraps modulo 256
//   fault                 : sticky protocol violation flag
//   phase                 : current state code, for debug
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; g/s high
// ARM     | g/s low for one cycle, telling the controller to go
// TRAVEL  | counting M-high cycles up to TRAVEL_CYCLES
// EVENT   | ev pulsed for one cycle
// BLOCKED | rd high for CLEAR_CYCLES cycles
// DWELL   | rd low, counting D-high cycles up to DWELL_CYCLES
// RETURN  | back pulsed for one cycle, trips incremented
module mef1_responder
  import mef1_pkg::*;
#(
  parameter int TRAVEL_CYCLES = 4,
  parameter int CLEAR_CYCLES  = 3,
  parameter int DWELL_CYCLES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       M,
  input  logic       D,
  input  logic       LEV,
  input  logic       Lerro,
  output logic       g,
  output logic       s,
  output logic       ev,
  output logic       rd,
  output logic       back,
  output logic [7:0] trips,
  output logic       fault,
  output logic [2:0] phase
);

  localparam int CW = $clog2(max3(TRAVEL_CYCLES, CLEAR_CYCLES, DWELL_CYCLES) + 1);

  state_t          state;
  logic            in_grace;
  logic            cnt_clr;
  logic            cnt_en;
  logic            cnt_tc;
  logic [CW-1:0]   cnt_limit;
  logic            viol;

  always_comb begin
    cnt_en    = 1'b0;
    cnt_limit = '0;
    case (state)
      ST_TRAVEL: begin
        cnt_en    = M;
        cnt_limit = CW'(TRAVEL_CYCLES);
      end
      ST_BLOCKED: begin
        cnt_en    = 1'b1;
        cnt_limit = CW'(CLEAR_CYCLES);
      end
      ST_DWELL: begin
        cnt_en    = D;
        cnt_limit = CW'(DWELL_CYCLES);
      end
      default: begin
        cnt_en    = 1'b0;
        cnt_limit = '0;
      end
    endcase
  end

  // Hold the counter at zero in the untimed states, and clear it on the edge
  // that leaves a timed state. Every timed state then starts counting from zero.
  assign cnt_clr = cnt_tc ||
                   !((state == ST_TRAVEL) || (state == ST_BLOCKED) || (state == ST_DWELL));

  phase_counter #(
    .WIDTH (CW)
  ) u_phase_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .limit (cnt_limit),
    .tc    (cnt_tc)
  );

  // The first cycle of each state is exempt from checking. This absorbs the
  // controller's one-edge lag when it follows a station transition.
  always_comb begin
    viol = 1'b0;
    if (!in_grace) begin
      case (state)
        ST_TRAVEL:  viol = !LEV || D;
        ST_BLOCKED: viol = !Lerro || D;
        ST_DWELL:   viol = !D;
        ST_RETURN:  viol = 1'b0;
        default:    viol = D;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      in_grace <= 1'b1;
      g        <= 1'b1;
      s        <= 1'b1;
      ev       <= 1'b0;
      rd       <= 1'b0;
      back     <= 1'b0;
      trips    <= 8'd0;
      fault    <= 1'b0;
    end else begin
      fault    <= fault | viol;
      in_grace <= 1'b0;
      g        <= 1'b1;
      s        <= 1'b1;
      ev       <= 1'b0;
      back     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_ARM;
            in_grace <= 1'b1;
            g        <= 1'b0;
            s        <= 1'b0;
          end
        end
        ST_ARM: begin
          state    <= ST_TRAVEL;
          in_grace <= 1'b1;
        end
        ST_TRAVEL: begin
          if (cnt_tc) begin
            state    <= ST_EVENT;
            in_grace <= 1'b1;
            ev       <= 1'b1;
          end
        end
        ST_EVENT: begin
          state    <= ST_BLOCKED;
          in_grace <= 1'b1;
          rd       <= 1'b1;
        end
        ST_BLOCKED: begin
          if (cnt_tc) begin
            state    <= ST_DWELL;
            in_grace <= 1'b1;
            rd       <= 1'b0;
          end
        end
        ST_DWELL: begin
          if (cnt_tc) begin
            state    <= ST_RETURN;
            in_grace <= 1'b1;
            back     <= 1'b1;
          end
        end
        ST_RETURN: begin
          state    <= ST_TRAVEL;
          in_grace <= 1'b1;
          trips    <= trips + 8'd1;
        end
        default: begin
          state    <= ST_IDLE;
          in_grace <= 1'b1;
          rd       <= 1'b0;
        end
      endcase
    end
  end

  assign phase = state;

endmodule

// File: tb/tb_mef1_responder.sv
module tb_mef1_responder;
  import mef1_pkg::*;

  localparam int TC = 4;
  localparam int CC = 3;
  localparam int DC = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       M, D, LEV, Lerro;
  logic       g, s, ev, rd, back, fault;
  logic [7:0] trips;
  logic [2:0] phase;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mef1_responder #(
    .TRAVEL_CYCLES (TC),
    .CLEAR_CYCLES  (CC),
    .DWELL_CYCLES  (DC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .M     (M),
    .D     (D),
    .LEV   (LEV),
    .Lerro (Lerro),
    .g     (g),
    .s     (s),
    .ev    (ev),
    .rd    (rd),
    .back  (back),
    .trips (trips),
    .fault (fault),
    .phase (phase)
  );

  typedef struct {
    bit st, m, d, lev, lerro;
    bit eg, es, eev, erd, eback, efault;
    int eph;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [16:0] snap();
    return {g, s, ev, rd, back, fault, phase, trips};
  endfunction

  function automatic logic [16:0] pack(input bit eg, input bit es, input bit eev,
                                       input bit erd, input bit eb, input bit ef,
                                       input int ph, input int tr);
    return {eg, es, eev, erd, eb, ef, 3'(ph), 8'(tr)};
  endfunction

  task automatic expect_now(input string name, input bit eg, input bit es, input bit eev,
                            input bit erd, input bit eb, input bit ef, input int ph, input int tr);
    check(name, 32'(snap()), 32'(pack(eg, es, eev, erd, eb, ef, ph, tr)));
  endtask

  task automatic step(input bit st, input bit m, input bit d, input bit lev, input bit lerro);
    @(negedge clk);
    start = st; M = m; D = d; LEV = lev; Lerro = lerro;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0; M = 1'b0; D = 1'b0; LEV = 1'b0; Lerro = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // The bench plays an ideal mef1 controller. Expected responder outputs come
  // from a per-trip schedule computed up front. In the randomized run, M may
  // drop for a few cycles before each counted M-high cycle.
  task automatic run_paired(input int n, input bit rnd, input string tag);
    int gaps[$];
    int tst[$];
    int evc[$];
    int bkc[$];
    bit mq[$];
    int t, sum, gv, evt, bk, last, k, ktrip, ph;
    logic [1:0] cst;
    bit nM, nD, nLEV, nLerro;
    logic [1:0] ncst;
    logic [16:0] expv;

    t = 2;
    for (int kk = 0; kk <= n; kk++) begin
      sum = 0;
      for (int j = 0; j < TC; j++) begin
        gv = rnd ? int'($urandom_range(0, 2)) : 0;
        gaps.push_back(gv);
        sum += gv;
      end
      tst.push_back(t);
      evt = t + TC + sum;
      evc.push_back(evt);
      bk = evt + CC + DC + 2;
      bkc.push_back(bk);
      t = bk + 1;
    end
    last = tst[n];

    do_reset();
    cst = S0;
    ktrip = 0;
    k = 0;
    for (int c = 0; c <= last; c++) begin
      if (c == 0)
        expv = pack(1, 1, 0, 0, 0, 0, PH_IDLE, 0);
      else if (c == 1)
        expv = pack(0, 0, 0, 0, 0, 0, PH_ARM, 0);
      else begin
        while (c > bkc[k]) k++;
        if (c < evc[k])            ph = 2;
        else if (c == evc[k])      ph = 3;
        else if (c <= evc[k] + CC) ph = 4;
        else if (c < bkc[k])       ph = 5;
        else                       ph = 6;
        expv = pack(1, 1, ph == 3, ph == 4, ph == 6, 0, ph, k % 256);
      end
      check($sformatf("%s cycle %0d", tag, c), 32'(snap()), 32'(expv));

      nM = M; nD = D; nLEV = LEV; nLerro = Lerro; ncst = cst;
      case (cst)
        S0: if (!g && !s) begin
          for (int j = 0; j < TC; j++) begin
            repeat (gaps[ktrip*TC + j]) mq.push_back(1'b0);
            mq.push_back(1'b1);
          end
          ktrip++;
          ncst = S1; nLEV = 1'b1;
          nM = (mq.size() != 0) ? mq.pop_front() : 1'b0;
        end
        S1: if (ev) begin
          ncst = S2; nM = 1'b0; nLEV = 1'b0; nLerro = 1'b1;
        end else
          nM = (mq.size() != 0) ? mq.pop_front() : 1'b0;
        S2: if (!rd) begin
          ncst = S3; nLerro = 1'b0; nD = 1'b1;
        end
        default: if (back) begin
          for (int j = 0; j < TC; j++) begin
            repeat (gaps[ktrip*TC + j]) mq.push_back(1'b0);
            mq.push_back(1'b1);
          end
          ktrip++;
          ncst = S1; nD = 1'b0; nLEV = 1'b1;
          nM = (mq.size() != 0) ? mq.pop_front() : 1'b0;
        end
      endcase
      start = (c == 0);
      @(posedge clk);
      #1;
      M = nM; D = nD; LEV = nLEV; Lerro = nLerro; cst = ncst;
      @(negedge clk);
    end
    check({tag, " trips_final"}, 32'(trips), 32'(n % 256));
  endtask

  initial begin
    vec_t tbl[$];
    reset = 1'b1;
    start = 1'b0; M = 1'b0; D = 1'b0; LEV = 1'b0; Lerro = 1'b0;

    // Each row: inputs for one cycle, then outputs after the edge.
    //             st m d l le  g s ev rd bk f  ph
    tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1});
    tbl.push_back('{0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 2});
    tbl.push_back('{0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 2});
    tbl.push_back('{0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 2});
    tbl.push_back('{1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 2});
    tbl.push_back('{0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 2});
    tbl.push_back('{0, 1, 0, 1, 0, 1, 1, 0, 0, 0, 1, 2});
    tbl.push_back('{0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 1, 2});
    tbl.push_back('{0, 1, 0, 1, 0, 1, 1, 0, 0, 0, 1, 2});
    tbl.push_back('{0, 1, 0, 1, 0, 1, 1, 0, 0, 0, 1, 2});
    tbl.push_back('{0, 1, 0, 1, 0, 1, 1, 1, 0, 0, 1, 3});
    tbl.push_back('{0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 1, 4});

    do_reset();
    #1;
    expect_now("reset_state", 1, 1, 0, 0, 0, 0, PH_IDLE, 0);
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].st, tbl[i].m, tbl[i].d, tbl[i].lev, tbl[i].lerro);
      expect_now($sformatf("vec%0d", i), tbl[i].eg, tbl[i].es, tbl[i].eev,
                 tbl[i].erd, tbl[i].eback, tbl[i].efault, tbl[i].eph, 0);
    end

    // D forced during BLOCKED, then a full trip, then an async reset in BLOCKED.
    do_reset();
    step(1, 0, 0, 0, 0);
    expect_now("arm", 0, 0, 0, 0, 0, 0, PH_ARM, 0);
    step(0, 0, 0, 0, 0);
    repeat (TC) step(0, 1, 0, 1, 0);
    expect_now("event", 1, 1, 1, 0, 0, 0, PH_EVENT, 0);
    step(0, 0, 0, 0, 0);
    expect_now("blocked_entry", 1, 1, 0, 1, 0, 0, PH_BLOCKED, 0);
    step(0, 0, 1, 0, 1);
    expect_now("d_in_blocked_grace", 1, 1, 0, 1, 0, 0, PH_BLOCKED, 0);
    step(0, 0, 1, 0, 1);
    expect_now("d_in_blocked_fault", 1, 1, 0, 1, 0, 1, PH_BLOCKED, 0);
    step(0, 0, 0, 0, 1);
    expect_now("dwell_entry", 1, 1, 0, 0, 0, 1, PH_DWELL, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    expect_now("fault_sticky", 1, 1, 0, 0, 0, 1, PH_DWELL, 0);
    step(0, 0, 1, 0, 0);
    expect_now("return", 1, 1, 0, 0, 1, 1, PH_RETURN, 0);
    step(0, 0, 1, 0, 0);
    expect_now("trip_done", 1, 1, 0, 0, 0, 1, PH_TRAVEL, 1);
    repeat (TC) step(0, 1, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    expect_now("blocked_again", 1, 1, 0, 1, 0, 1, PH_BLOCKED, 1);
    #2;
    reset = 1'b1;
    #1;
    check("rd_async_drop", 32'(rd), 32'(0));
    expect_now("async_reset", 1, 1, 0, 0, 0, 0, PH_IDLE, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    step(1, 0, 0, 0, 0);
    expect_now("restart_arm", 0, 0, 0, 0, 0, 0, PH_ARM, 0);
    step(0, 0, 0, 0, 0);
    expect_now("restart_travel", 1, 1, 0, 0, 0, 0, PH_TRAVEL, 0);

    run_paired(300, 1'b0, "paired300");
    check("trips_after_300", 32'(trips), 32'(44));
    run_paired(25, 1'b1, "paired_rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
